regfile_mp: RTL



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/regfile_mp.sv | 92 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
// Decode and writeback stages import the same addr_t/word_t definitions.
package regfile_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [XLEN-1:0]   word_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and reservation bus of the multi-port register file.
// The master side is the core (decode and writeback); the slave side is the register file.
interface regfile_mp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned NUM_WRITE  = 1
);

    logic [NUM_READ*ADDR_WIDTH-1:0]  rs_address;
    logic [NUM_READ*DATA_WIDTH-1:0]  rs_data;
    logic [NUM_READ-1:0]             rs_busy;
    logic [NUM_WRITE-1:0]            wr_enable;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_address;
    logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data;
    logic                            rsv_enable;
    logic [ADDR_WIDTH-1:0]           rsv_address;

    modport master (
        output rs_address, wr_enable, wr_address, wr_data, rsv_enable, rsv_address,
        input  rs_data, rs_busy
    );

    modport slave (
        input  rs_address, wr_enable, wr_address, wr_data, rsv_enable, rsv_address,
        output rs_data, rs_busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: reservations set, enabled writes clear, set wins on a tie.
// Read ports see the registered busy bits only; a same-cycle release is not forwarded.
module regfile_scoreboard #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned NUM_WRITE  = 1,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            rsv_enable,
    input  logic [ADDR_WIDTH-1:0]           rsv_address,
    input  logic [NUM_WRITE-1:0]            wr_enable,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_address,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  rs_address,
    output logic [NUM_READ-1:0]             rs_busy_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Releases first, then the reservation, so a new producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < int'(NUM_WRITE); w++) begin
            if (wr_enable[w]) begin
                busy_d[wr_address[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (rsv_enable) begin
            busy_d[rsv_address] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rs_busy_c = '0;
        for (int r = 0; r < int'(NUM_READ); r++) begin
            rs_busy_c[r] = busy_q[rs_address[r*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass,
// hard-wired zero register and a reservation scoreboard.
module regfile_mp #(
    parameter int unsigned DATA_WIDTH = regfile_pkg::XLEN,
    parameter int unsigned NUM_REGS   = regfile_pkg::NUM_REGS,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned NUM_WRITE  = 1,
    parameter bit          BYPASS     = 1'b1,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    regfile_mp_if.slave  bus
);

    import regfile_pkg::*;

    localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_READ*DATA_WIDTH-1:0] rs_data_c;
    logic [NUM_READ-1:0]            rs_busy_c;

    // Ascending port order lets the highest-index enabled writer win a conflict.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < int'(NUM_WRITE); w++) begin
            if (bus.wr_enable[w]) begin
                regs_d[bus.wr_address[w*ADDR_WIDTH +: ADDR_WIDTH]] =
                    bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (ZERO_REG) begin
            regs_d[ZERO_ADDR] = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass is gated by reset so reads show zero for the whole time reset is held.
    always_comb begin
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rv;
        rs_data_c = '0;
        ra        = '0;
        rv        = '0;
        for (int r = 0; r < int'(NUM_READ); r++) begin
            ra = bus.rs_address[r*ADDR_WIDTH +: ADDR_WIDTH];
            rv = regs_q[ra];
            if (BYPASS && reset_n) begin
                for (int w = 0; w < int'(NUM_WRITE); w++) begin
                    if (bus.wr_enable[w] && (bus.wr_address[w*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
                        rv = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            if (ZERO_REG && (ra == ZERO_ADDR)) begin
                rv = '0;
            end
            rs_data_c[r*DATA_WIDTH +: DATA_WIDTH] = rv;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_READ   (NUM_READ),
        .NUM_WRITE  (NUM_WRITE),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clock       (clock),
        .reset_n     (reset_n),
        .rsv_enable  (bus.rsv_enable),
        .rsv_address (bus.rsv_address),
        .wr_enable   (bus.wr_enable),
        .wr_address  (bus.wr_address),
        .rs_address  (bus.rs_address),
        .rs_busy_c   (rs_busy_c)
    );

    assign bus.rs_data = rs_data_c;
    assign bus.rs_busy = rs_busy_c;

endmodule
